// File: rtl/n_bits_select_stream_demux_pkg.sv
// Shared types and sizing helpers for the select-driven stream demux
// and its one-hot decoder.
package n_bits_demux_pkg;

    typedef enum logic {
        DEMUX_ROUTE = 1'b0,
        DEMUX_BCAST = 1'b1
    } demux_mode_t;

    // Occupancy of the output stage, fully implied by the pending mask and mode.
    typedef enum logic [1:0] {
        DEMUX_IDLE       = 2'd0,
        DEMUX_ROUTE_WAIT = 2'd1,
        DEMUX_BCAST_WAIT = 2'd2
    } demux_state_t;

    function automatic int channels(input int sel_bits);
        return 1 << sel_bits;
    endfunction

endpackage

// File: rtl/n_bits_select_stream_demux_if.sv
// Handshake bundle for the stream demux: one producer side, N consumer channels.
// The master modport is the environment driving the demux; slave is the demux.
interface n_bits_select_stream_demux_if #(
    parameter int SEL_BITS   = 4,
    parameter int DATA_WIDTH = 1
);
    localparam int N = n_bits_demux_pkg::channels(SEL_BITS);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [SEL_BITS-1:0]   select;
    logic                  mode;
    logic [N-1:0]          out_valid;
    logic [N-1:0]          out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  busy;

    modport master (
        output in_valid, in_data, select, mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, select, mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/n_bits_select_stream_demux_onehot_decoder.sv
// Combinational binary-select to one-hot decoder; replaces the old hand-built
// demux trees and is reused wherever a channel mask is needed.
module n_bits_select_onehot_decoder
    import n_bits_demux_pkg::*;
#(
    parameter int SEL_BITS = 4
) (
    input  logic [SEL_BITS-1:0]           select,
    output logic [channels(SEL_BITS)-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < channels(SEL_BITS); gi++) begin : g_dec
            assign onehot[gi] = (select == SEL_BITS'(gi));
        end
    endgenerate

endmodule

// File: rtl/n_bits_select_stream_demux.sv
// Registered one-entry demux: routes each accepted word to one channel or
// broadcasts it to all, tracking per-channel completion in a pending mask.
module n_bits_select_stream_demux
    import n_bits_demux_pkg::*;
#(
    parameter int SEL_BITS   = 4,
    parameter int DATA_WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    n_bits_select_stream_demux_if.slave  bus
);

    localparam int N = channels(SEL_BITS);

    logic [N-1:0]          pending_q;
    logic [N-1:0]          pending_next;
    logic [N-1:0]          remaining;
    logic [N-1:0]          sel_onehot;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_next;
    demux_mode_t           mode_q;
    demux_mode_t           mode_next;
    demux_mode_t           in_mode;
    demux_state_t          state;
    logic                  done;
    logic                  in_ready;
    logic                  accept;

    n_bits_select_onehot_decoder #(
        .SEL_BITS (SEL_BITS)
    ) u_decoder (
        .select (bus.select),
        .onehot (sel_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            data_q    <= '0;
            mode_q    <= DEMUX_ROUTE;
        end else begin
            pending_q <= pending_next;
            data_q    <= data_next;
            mode_q    <= mode_next;
        end
    end

    always_comb begin
        state        = DEMUX_IDLE;
        remaining    = pending_q & ~bus.out_ready;
        done         = (remaining == '0);
        in_mode      = demux_mode_t'(bus.mode);
        pending_next = remaining;
        data_next    = data_q;
        mode_next    = mode_q;

        if (pending_q != '0) begin
            state = (mode_q == DEMUX_BCAST) ? DEMUX_BCAST_WAIT : DEMUX_ROUTE_WAIT;
        end

        // Ready may rise in the same cycle the last pending channel completes,
        // which is what gives back-to-back throughput.
        in_ready = (state == DEMUX_IDLE) || done;
        accept   = bus.in_valid && in_ready;

        // A new word replaces the mask outright; leftover bits are never merged.
        if (accept) begin
            data_next    = bus.in_data;
            mode_next    = in_mode;
            pending_next = (in_mode == DEMUX_BCAST) ? {N{1'b1}} : sel_onehot;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = pending_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = (state != DEMUX_IDLE);

endmodule

// File: tb/tb_n_bits_select_stream_demux.sv
// Directed bench for the stream demux: route, back-pressure, broadcast,
// back-to-back, asynchronous reset and the single-select-bit corner.
module tb_n_bits_select_stream_demux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    n_bits_select_stream_demux_if #(.SEL_BITS(4), .DATA_WIDTH(8)) a ();
    n_bits_select_stream_demux_if #(.SEL_BITS(1), .DATA_WIDTH(8)) b ();

    n_bits_select_stream_demux #(.SEL_BITS(4), .DATA_WIDTH(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a.slave)
    );

    n_bits_select_stream_demux #(.SEL_BITS(1), .DATA_WIDTH(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_onehot;

    initial begin
        a.in_valid = 1'b0; a.in_data = '0; a.select = '0; a.mode = 1'b0; a.out_ready = '0;
        b.in_valid = 1'b0; b.in_data = '0; b.select = '0; b.mode = 1'b0; b.out_ready = '0;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", a.out_valid, 16'h0000);
        chk("rst_out_data", a.out_data, 8'h00);
        chk("rst_busy", a.busy, 1'b0);
        chk("rst_in_ready", a.in_ready, 1'b1);
        chk("rst_b_out_valid", b.out_valid, 2'b00);
        rst_n = 1'b1;
        tick();
        $display("reset released");

        // Route basic: 0xA5 to channel 9
        a.out_ready = 16'hFFFF;
        a.in_valid = 1'b1; a.in_data = 8'hA5; a.select = 4'd9; a.mode = 1'b0;
        #1 chk("route_in_ready", a.in_ready, 1'b1);
        tick();
        a.in_valid = 1'b0;
        chk("route_out_valid", a.out_valid, 16'h0200);
        chk("route_out_data", a.out_data, 8'hA5);
        chk("route_busy", a.busy, 1'b1);
        tick();
        chk("route_drain", a.out_valid, 16'h0000);
        chk("route_idle_busy", a.busy, 1'b0);
        $display("route: 0xA5 -> ch9");

        // Back-pressure on channel 3, next word offered throughout
        a.out_ready = 16'hFFF7;
        a.in_valid = 1'b1; a.in_data = 8'h11; a.select = 4'd3;
        tick();
        a.in_data = 8'h22; a.select = 4'd5;
        for (int c = 0; c < 4; c++) begin
            chk("bp_hold_valid", a.out_valid, 16'h0008);
            chk("bp_hold_data", a.out_data, 8'h11);
            chk("bp_in_ready_low", a.in_ready, 1'b0);
            tick();
        end
        a.out_ready = 16'hFFFF;
        #1 chk("bp_release_ready", a.in_ready, 1'b1);
        chk("bp_release_valid", a.out_valid, 16'h0008);
        tick();
        a.in_valid = 1'b0;
        chk("bp_next_valid", a.out_valid, 16'h0020);
        chk("bp_next_data", a.out_data, 8'h22);
        tick();
        chk("bp_drain", a.out_valid, 16'h0000);
        $display("back-pressure: ch3 held 4 cycles, 0x22 -> ch5 same-cycle accept");

        // Broadcast staggered
        a.out_ready = 16'h0000;
        a.in_valid = 1'b1; a.in_data = 8'h3C; a.mode = 1'b1;
        tick();
        a.in_valid = 1'b0; a.mode = 1'b0;
        chk("bc_all_valid", a.out_valid, 16'hFFFF);
        chk("bc_data", a.out_data, 8'h3C);
        a.out_ready = 16'h00FF;
        #1 chk("bc_ready_low1", a.in_ready, 1'b0);
        tick();
        a.out_ready = 16'h0000;
        chk("bc_half_valid", a.out_valid, 16'hFF00);
        #1 chk("bc_ready_low2", a.in_ready, 1'b0);
        tick();
        chk("bc_half_hold", a.out_valid, 16'hFF00);
        a.out_ready = 16'hFFFF;
        #1 chk("bc_ready_rise", a.in_ready, 1'b1);
        tick();
        chk("bc_done_valid", a.out_valid, 16'h0000);
        chk("bc_done_busy", a.busy, 1'b0);
        chk("bc_data_kept", a.out_data, 8'h3C);
        $display("broadcast: 0x3C staggered completion");

        // Back-to-back route, 16 words
        a.out_ready = 16'hFFFF;
        a.in_valid = 1'b1; a.in_data = 8'h40; a.select = 4'd0;
        tick();
        for (int i = 0; i < 16; i++) begin
            exp_onehot = 16'h0001 << i;
            chk("b2b_valid", a.out_valid, exp_onehot);
            chk("b2b_data", a.out_data, 8'h40 + 8'(i));
            if (i < 15) begin
                a.in_data = 8'h40 + 8'(i + 1);
                a.select = 4'(i + 1);
            end else begin
                a.in_valid = 1'b0;
            end
            #1 chk("b2b_in_ready", a.in_ready, 1'b1);
            tick();
        end
        chk("b2b_drain", a.out_valid, 16'h0000);
        $display("back-to-back: 16 words, one per cycle");

        // Reset mid-broadcast
        a.out_ready = 16'h0000;
        a.in_valid = 1'b1; a.in_data = 8'h5A; a.mode = 1'b1;
        tick();
        a.in_valid = 1'b0; a.mode = 1'b0;
        a.out_ready = 16'h0F0F;
        tick();
        a.out_ready = 16'h0000;
        chk("rb_partial", a.out_valid, 16'hF0F0);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_async_valid", a.out_valid, 16'h0000);
        chk("rb_async_busy", a.busy, 1'b0);
        chk("rb_async_data", a.out_data, 8'h00);
        chk("rb_async_ready", a.in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rb_after_valid", a.out_valid, 16'h0000);
        chk("rb_after_busy", a.busy, 1'b0);
        a.out_ready = 16'hFFFF;
        a.in_valid = 1'b1; a.in_data = 8'h77; a.select = 4'd2;
        tick();
        a.in_valid = 1'b0;
        chk("rb_recover_valid", a.out_valid, 16'h0004);
        chk("rb_recover_data", a.out_data, 8'h77);
        tick();
        $display("reset mid-broadcast: cleared, recovered");

        // SEL_BITS = 1 broadcast corner
        b.out_ready = 2'b00;
        b.in_valid = 1'b1; b.in_data = 8'hC3; b.mode = 1'b1;
        tick();
        b.in_valid = 1'b0; b.mode = 1'b0;
        chk("n2_all_valid", b.out_valid, 2'b11);
        chk("n2_data", b.out_data, 8'hC3);
        b.out_ready = 2'b10;
        tick();
        chk("n2_half_valid", b.out_valid, 2'b01);
        b.out_ready = 2'b01;
        #1 chk("n2_ready_rise", b.in_ready, 1'b1);
        tick();
        chk("n2_done_valid", b.out_valid, 2'b00);
        chk("n2_done_busy", b.busy, 1'b0);
        $display("sel_bits=1 broadcast: 11 -> 01 -> 00");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
